// File: rtl/fadd_pkg.sv
// Shared definitions for the floating-point adder stages: rounding modes,
// field-width helpers and operand classification.
package fadd_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic is_inf;
    logic is_nan;
    logic is_snan;
    logic is_zero;
  } fp_class_t;

  // Internal significand: carry, PRECISION significand bits, guard, sticky.
  function automatic int sig_width(input int precision);
    return precision + 3;
  endfunction

  function automatic int op_width(input int expwidth, input int precision);
    return expwidth + precision;
  endfunction

  function automatic fp_class_t fp_classify(input logic exp_ones, input logic exp_zero,
                                            input logic frac_zero, input logic frac_msb);
    fp_class_t c;
    c.is_inf  = exp_ones & frac_zero;
    c.is_nan  = exp_ones & ~frac_zero;
    c.is_snan = exp_ones & ~frac_zero & ~frac_msb;
    c.is_zero = exp_zero & frac_zero;
    return c;
  endfunction

endpackage

// File: rtl/fadd_lzc.sv
// Combinational leading-zero counter; an all-zero input returns N.
module fadd_lzc #(
  parameter int N  = 6,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);

  // Scanning upward lets the highest set bit have the final word.
  always_comb begin
    cnt_o = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (in_i[i]) cnt_o = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_s1.sv
// First adder stage: unpack and classify operands, compute far and near path
// candidates, and register them behind a one-entry valid/ready slot.
module fadd_s1
  import fadd_pkg::*;
#(
  parameter int EXPWIDTH  = 5,
  parameter int PRECISION = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXPWIDTH+PRECISION-1:0] a_i,
  input  logic [EXPWIDTH+PRECISION-1:0] b_i,
  input  logic [2:0]             rm_i,
  input  logic                   mul_of_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_far_sign_o,
  output logic [EXPWIDTH-1:0]    out_far_exp_o,
  output logic [PRECISION+2:0]   out_far_sig_o,
  output logic                   out_near_sign_o,
  output logic [EXPWIDTH-1:0]    out_near_exp_o,
  output logic [PRECISION+2:0]   out_near_sig_o,
  output logic                   out_sel_far_path_o,
  output logic [2:0]             out_rm_o,
  output logic                   out_far_mul_of_o,
  output logic                   out_near_sig_is_zero_o,
  output logic                   out_special_case_valid_o,
  output logic                   out_special_case_inv_o,
  output logic                   out_special_case_nan_o
);

  localparam int W   = op_width(EXPWIDTH, PRECISION);
  localparam int SW  = sig_width(PRECISION);
  localparam int FW  = PRECISION - 1;
  localparam int NW  = PRECISION + 2;
  localparam int LZW = $clog2(NW + 1);
  localparam int CW  = (EXPWIDTH > LZW) ? EXPWIDTH : LZW;
  localparam logic [EXPWIDTH-1:0] SAT = EXPWIDTH'(PRECISION + 2);

  // ---------------- unpack ----------------
  logic                a_sign, b_sign, a_hid, b_hid;
  logic [EXPWIDTH-1:0] a_exp, b_exp, a_exp_eff, b_exp_eff;
  logic [FW-1:0]       a_frac, b_frac;
  logic [PRECISION-1:0] a_sig, b_sig;
  fp_class_t           a_cls, b_cls;

  assign a_sign    = a_i[W-1];
  assign b_sign    = b_i[W-1];
  assign a_exp     = a_i[W-2:FW];
  assign b_exp     = b_i[W-2:FW];
  assign a_frac    = a_i[FW-1:0];
  assign b_frac    = b_i[FW-1:0];
  assign a_hid     = |a_exp;
  assign b_hid     = |b_exp;
  assign a_exp_eff = a_hid ? a_exp : EXPWIDTH'(1);
  assign b_exp_eff = b_hid ? b_exp : EXPWIDTH'(1);
  assign a_sig     = {a_hid, a_frac};
  assign b_sig     = {b_hid, b_frac};
  assign a_cls     = fp_classify(&a_exp, ~a_hid, ~|a_frac, a_frac[FW-1]);
  assign b_cls     = fp_classify(&b_exp, ~b_hid, ~|b_frac, b_frac[FW-1]);

  logic unused_zero;
  assign unused_zero = a_cls.is_zero | b_cls.is_zero;

  // On an exact magnitude tie a_i stays the big operand.
  logic                 swap, eff_sub, big_sign;
  logic [EXPWIDTH-1:0]  big_exp, sml_exp, d;
  logic [SW-1:0]        big_ext, sml_ext;

  assign swap     = {b_exp_eff, b_sig} > {a_exp_eff, a_sig};
  assign big_sign = swap ? b_sign : a_sign;
  assign big_exp  = swap ? b_exp_eff : a_exp_eff;
  assign sml_exp  = swap ? a_exp_eff : b_exp_eff;
  assign big_ext  = {1'b0, (swap ? b_sig : a_sig), 2'b00};
  assign sml_ext  = {1'b0, (swap ? a_sig : b_sig), 2'b00};
  assign eff_sub  = a_sign ^ b_sign;
  assign d        = big_exp - sml_exp;

  // ---------------- far path ----------------
  logic [EXPWIDTH-1:0] far_sh;
  logic [SW-1:0]       far_shifted, far_mask, far_aligned, far_sig_d;
  logic                far_lost;

  assign far_sh      = (d > SAT) ? SAT : d;
  assign far_shifted = sml_ext >> far_sh;
  assign far_mask    = (SW'(1) << far_sh) - SW'(1);
  assign far_lost    = |(sml_ext & far_mask);
  assign far_aligned = {far_shifted[SW-1:1], far_shifted[0] | far_lost};
  assign far_sig_d   = eff_sub ? (big_ext - far_aligned) : (big_ext + far_aligned);

  // ---------------- near path ----------------
  logic [SW-1:0]       near_b, near_diff, near_sig_d;
  logic [LZW-1:0]      near_lz;
  logic [CW-1:0]       lz_c, lim_c, near_sh;
  logic [EXPWIDTH-1:0] near_exp_d;
  logic                near_zero_d, near_sign_d;

  assign near_b    = (d != '0) ? (sml_ext >> 1) : sml_ext;
  assign near_diff = big_ext - near_b;

  fadd_lzc #(.N(NW), .CW(LZW)) u_lzc (
    .in_i  (near_diff[NW-1:0]),
    .cnt_o (near_lz)
  );

  // Normalization never drives the exponent below the subnormal floor.
  assign lz_c        = CW'(near_lz);
  assign lim_c       = CW'(big_exp - EXPWIDTH'(1));
  assign near_sh     = (lz_c < lim_c) ? lz_c : lim_c;
  assign near_sig_d  = near_diff << near_sh;
  assign near_exp_d  = near_sig_d[PRECISION+1] ? (big_exp - EXPWIDTH'(near_sh)) : '0;
  assign near_zero_d = (near_diff == '0);
  assign near_sign_d = near_zero_d ? (rm_i == RM_RDN) : big_sign;

  // ---------------- special cases ----------------
  logic spec_valid_d, spec_nan_d, spec_inv_d, inf_sub, any_nan, any_inf;
  logic sel_far_d, far_sign_d;

  assign inf_sub      = a_cls.is_inf & b_cls.is_inf & eff_sub;
  assign any_nan      = a_cls.is_nan | b_cls.is_nan;
  assign any_inf      = a_cls.is_inf | b_cls.is_inf;
  assign spec_valid_d = (&a_exp) | (&b_exp);
  assign spec_nan_d   = any_nan | inf_sub;
  assign spec_inv_d   = a_cls.is_snan | b_cls.is_snan | inf_sub;

  always_comb begin
    sel_far_d  = ~eff_sub | (d > EXPWIDTH'(1));
    far_sign_d = big_sign;
    if (any_inf & ~spec_nan_d) begin
      sel_far_d  = 1'b1;
      far_sign_d = a_cls.is_inf ? a_sign : b_sign;
    end
  end

  // ---------------- pipeline register ----------------
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds with frozen data until ready is seen.
  logic                 load;
  logic                 valid_q, far_sign_q, near_sign_q, sel_far_q, mul_of_q;
  logic                 near_zero_q, spec_valid_q, spec_inv_q, spec_nan_q;
  logic [EXPWIDTH-1:0]  far_exp_q, near_exp_q;
  logic [SW-1:0]        far_sig_q, near_sig_q;
  logic [2:0]           rm_q;

  assign in_ready_o = ~valid_q | out_ready_i;
  assign load       = in_valid_i & in_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      far_sign_q   <= 1'b0;
      far_exp_q    <= '0;
      far_sig_q    <= '0;
      near_sign_q  <= 1'b0;
      near_exp_q   <= '0;
      near_sig_q   <= '0;
      sel_far_q    <= 1'b0;
      rm_q         <= '0;
      mul_of_q     <= 1'b0;
      near_zero_q  <= 1'b0;
      spec_valid_q <= 1'b0;
      spec_inv_q   <= 1'b0;
      spec_nan_q   <= 1'b0;
    end else if (load) begin
      valid_q      <= 1'b1;
      far_sign_q   <= far_sign_d;
      far_exp_q    <= big_exp;
      far_sig_q    <= far_sig_d;
      near_sign_q  <= near_sign_d;
      near_exp_q   <= near_exp_d;
      near_sig_q   <= near_sig_d;
      sel_far_q    <= sel_far_d;
      rm_q         <= rm_i;
      mul_of_q     <= mul_of_i;
      near_zero_q  <= near_zero_d;
      spec_valid_q <= spec_valid_d;
      spec_inv_q   <= spec_inv_d;
      spec_nan_q   <= spec_nan_d;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o              = valid_q;
  assign out_far_sign_o           = far_sign_q;
  assign out_far_exp_o            = far_exp_q;
  assign out_far_sig_o            = far_sig_q;
  assign out_near_sign_o          = near_sign_q;
  assign out_near_exp_o           = near_exp_q;
  assign out_near_sig_o           = near_sig_q;
  assign out_sel_far_path_o       = sel_far_q;
  assign out_rm_o                 = rm_q;
  assign out_far_mul_of_o         = mul_of_q;
  assign out_near_sig_is_zero_o   = near_zero_q;
  assign out_special_case_valid_o = spec_valid_q;
  assign out_special_case_inv_o   = spec_inv_q;
  assign out_special_case_nan_o   = spec_nan_q;

endmodule

// File: tb/tb_fadd_s1.sv
// Directed bench for fadd_s1 (EXPWIDTH=5, PRECISION=4) with hand-computed
// expected values checked by immediate assertions.
module tb_fadd_s1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [8:0] a, b;
  logic [2:0] rm;
  logic       mul_of;
  logic       out_valid, out_ready;
  logic       far_sign, near_sign, sel_far, far_mul_of, near_zero;
  logic [4:0] far_exp, near_exp;
  logic [6:0] far_sig, near_sig;
  logic [2:0] out_rm;
  logic       sp_valid, sp_inv, sp_nan;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fadd_s1 #(.EXPWIDTH(5), .PRECISION(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid_i               (in_valid),
    .in_ready_o               (in_ready),
    .a_i                      (a),
    .b_i                      (b),
    .rm_i                     (rm),
    .mul_of_i                 (mul_of),
    .out_valid_o              (out_valid),
    .out_ready_i              (out_ready),
    .out_far_sign_o           (far_sign),
    .out_far_exp_o            (far_exp),
    .out_far_sig_o            (far_sig),
    .out_near_sign_o          (near_sign),
    .out_near_exp_o           (near_exp),
    .out_near_sig_o           (near_sig),
    .out_sel_far_path_o       (sel_far),
    .out_rm_o                 (out_rm),
    .out_far_mul_of_o         (far_mul_of),
    .out_near_sig_is_zero_o   (near_zero),
    .out_special_case_valid_o (sp_valid),
    .out_special_case_inv_o   (sp_inv),
    .out_special_case_nan_o   (sp_nan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one operand pair for a single edge, then sample the registered result.
  task automatic apply(input logic [8:0] av, input logic [8:0] bv,
                       input logic [2:0] rmv, input logic mov);
    a        = av;
    b        = bv;
    rm       = rmv;
    mul_of   = mov;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [51:0] all_out;
  assign all_out = {out_valid, far_sign, far_exp, far_sig, near_sign, near_exp, near_sig,
                    sel_far, out_rm, far_mul_of, near_zero, sp_valid, sp_inv, sp_nan};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; rm = '0; mul_of = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(all_out != '0), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // 1.0 + 1.0
    apply(9'h078, 9'h078, 3'd0, 1'b1);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_sel_far", 32'(sel_far), 32'd1);
    chk("add_far_exp", 32'(far_exp), 32'd15);
    chk("add_far_sig", 32'(far_sig), 32'h40);
    chk("add_far_sign", 32'(far_sign), 32'd0);
    chk("add_special", 32'(sp_valid), 32'd0);
    chk("add_mul_of", 32'(far_mul_of), 32'd1);

    // Sticky alignment, d=5, and the swapped operand order
    apply(9'h078, 9'h050, 3'd3, 1'b0);
    chk("sticky_far_exp", 32'(far_exp), 32'd15);
    chk("sticky_far_sig", 32'(far_sig), 32'h21);
    chk("sticky_sel_far", 32'(sel_far), 32'd1);
    chk("sticky_rm", 32'(out_rm), 32'd3);
    chk("sticky_mul_of", 32'(far_mul_of), 32'd0);
    apply(9'h050, 9'h078, 3'd0, 1'b0);
    chk("swap_far_exp", 32'(far_exp), 32'd15);
    chk("swap_far_sig", 32'(far_sig), 32'h21);

    // Far subtract: 1.0 - 2^-5
    apply(9'h078, 9'h150, 3'd0, 1'b0);
    chk("fsub_far_sig", 32'(far_sig), 32'h1F);
    chk("fsub_far_sign", 32'(far_sign), 32'd0);
    chk("fsub_sel_far", 32'(sel_far), 32'd1);

    // Near subtract: 1.0 - 0.1111b = 2^-4
    apply(9'h078, 9'h177, 3'd0, 1'b0);
    chk("near_sel_far", 32'(sel_far), 32'd0);
    chk("near_sig", 32'(near_sig), 32'h20);
    chk("near_exp", 32'(near_exp), 32'd11);
    chk("near_zero", 32'(near_zero), 32'd0);
    chk("near_sign", 32'(near_sign), 32'd0);

    // Near subtract clamped at the subnormal floor
    apply(9'h008, 9'h107, 3'd0, 1'b0);
    chk("sub_near_sig", 32'(near_sig), 32'h04);
    chk("sub_near_exp", 32'(near_exp), 32'd0);

    // Exact cancellation, sign from the rounding mode
    apply(9'h078, 9'h178, 3'd0, 1'b0);
    chk("cancel_sel_far", 32'(sel_far), 32'd0);
    chk("cancel_zero", 32'(near_zero), 32'd1);
    chk("cancel_sign_rne", 32'(near_sign), 32'd0);
    chk("cancel_exp", 32'(near_exp), 32'd0);
    apply(9'h078, 9'h178, 3'd2, 1'b0);
    chk("cancel_sign_rdn", 32'(near_sign), 32'd1);

    // Special cases
    apply(9'h0FA, 9'h078, 3'd0, 1'b0);
    chk("snan_flags", 32'({sp_valid, sp_nan, sp_inv}), 32'b111);
    apply(9'h0FC, 9'h078, 3'd0, 1'b0);
    chk("qnan_flags", 32'({sp_valid, sp_nan, sp_inv}), 32'b110);
    apply(9'h0F8, 9'h1F8, 3'd0, 1'b0);
    chk("infsub_flags", 32'({sp_valid, sp_nan, sp_inv}), 32'b111);
    apply(9'h1F8, 9'h078, 3'd0, 1'b0);
    chk("inf_flags", 32'({sp_valid, sp_nan, sp_inv}), 32'b100);
    chk("inf_far_sign", 32'(far_sign), 32'd1);
    chk("inf_sel_far", 32'(sel_far), 32'd1);
    apply(9'h078, 9'h1F8, 3'd0, 1'b0);
    chk("infb_far_sign", 32'(far_sign), 32'd1);
    chk("infb_sel_far", 32'(sel_far), 32'd1);

    // Drain with no new input
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    apply(9'h078, 9'h078, 3'd1, 1'b0);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    a = 9'h078; b = 9'h050; rm = 3'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sig", 32'(far_sig), 32'h40);
      chk("bp_hold_rm", 32'(out_rm), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_sig", 32'(far_sig), 32'h21);
    chk("bp_second_rm", 32'(out_rm), 32'd4);

    // Reset while holding an entry and offering another
    a = 9'h0FA; b = 9'h078; mul_of = 1'b1; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_outputs", 32'(all_out != '0), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
